// File: rtl/sitcpxg_tx_arb_pkg.sv
// sitcpxg_tx_arbiter shared types and constants.
// Burst state, port widths and byte-count clamp helpers.
package sitcpxg_tx_arb_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } arb_state_t;

  localparam int TX_W  = 64;
  localparam int TXB_W = 4;

  localparam logic [TXB_W-1:0] B_MAX = 4'd8;

  function automatic logic [TXB_W-1:0] clamp_b(
    input logic [TXB_W-1:0] b
  );
    return (b > B_MAX) ? B_MAX : b;
  endfunction

  function automatic logic bad_b(
    input logic [TXB_W-1:0] b
  );
    return (b == '0) || (b > B_MAX);
  endfunction

endpackage

// File: rtl/sitcpxg_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first request at or
// after the pointer, wrapping, as one-hot plus index.
module sitcpxg_rr_pick #(
  parameter int N_CH = 4,
  parameter int PW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin : pick
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N_CH; k++) begin
      j = (int'(ptr) + k) % N_CH;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin burst scheduler sharing the SiTCP 10GbE
// TCP transmit port among N_CH user sources.
module sitcpxg_tx_arbiter
  import sitcpxg_tx_arb_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 64,
  parameter int IDLE_TO   = 16
) (
  input  logic                    XGMII_CLOCK,
  input  logic                    RSTs,
  input  logic                    USER_SESSION_ESTABLISHED,
  input  logic                    USER_TX_AFULL,
  input  logic [N_CH-1:0]         CH_VAL,
  input  logic [TX_W*N_CH-1:0]    CH_D,
  input  logic [TXB_W*N_CH-1:0]   CH_B,
  input  logic [N_CH-1:0]         CH_LAST,
  output logic [N_CH-1:0]         CH_RDY,
  output logic [N_CH-1:0]         CH_GRANT,
  output logic [TX_W-1:0]         USER_TX_D,
  output logic [TXB_W-1:0]        USER_TX_B,
  output logic                    BAD_LEN
);

  localparam int PW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WCW = $clog2(MAX_BURST + 1);
  localparam int ICW = 8;

  arb_state_t       state, state_n;
  logic [N_CH-1:0]  grant_n;
  logic [PW-1:0]    gidx, gidx_n;
  logic [PW-1:0]    ptr, ptr_n;
  logic [WCW-1:0]   wcnt, wcnt_n, wnext;
  logic [ICW-1:0]   icnt, icnt_n, inext;
  logic [TX_W-1:0]  tx_d_n;
  logic [TXB_W-1:0] tx_b_n;
  logic             bad_n;

  logic [N_CH-1:0]  pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic             est;
  logic             g_val;
  logic             g_last;
  logic [TX_W-1:0]  g_d;
  logic [TXB_W-1:0] g_b;
  logic             accept;
  logic [PW-1:0]    ptr_inc;

  sitcpxg_rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_pick (
    .req (CH_VAL),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign est    = USER_SESSION_ESTABLISHED;
  assign g_val  = CH_VAL[gidx];
  assign g_last = CH_LAST[gidx];
  assign g_d    = CH_D[int'(gidx)*TX_W +: TX_W];
  assign g_b    = CH_B[int'(gidx)*TXB_W +: TXB_W];

  // Grant is all-zero outside SEND, so it alone gates ready.
  assign CH_RDY = CH_GRANT & CH_VAL &
                  {N_CH{~USER_TX_AFULL & est}};

  assign accept = (state == SEND) && g_val &&
                  !USER_TX_AFULL && est;

  always_comb begin
    state_n = state;
    grant_n = CH_GRANT;
    gidx_n  = gidx;
    ptr_n   = ptr;
    wcnt_n  = wcnt;
    icnt_n  = icnt;
    tx_d_n  = USER_TX_D;
    tx_b_n  = '0;
    bad_n   = BAD_LEN;
    wnext   = wcnt + 1'b1;
    inext   = icnt + 1'b1;
    ptr_inc = (gidx == PW'(N_CH - 1)) ? '0 : gidx + 1'b1;
    unique case (state)
      IDLE: begin
        if (est && pick_any) begin
          state_n = SEND;
          grant_n = pick_gnt;
          gidx_n  = pick_idx;
          wcnt_n  = '0;
          icnt_n  = '0;
        end
      end
      SEND: begin
        if (!est) begin
          // Pointer kept so the same channel resumes first.
          state_n = IDLE;
          grant_n = '0;
        end else begin
          if (accept) begin
            tx_d_n = g_d;
            tx_b_n = clamp_b(g_b);
            bad_n  = BAD_LEN | bad_b(g_b);
            wcnt_n = wnext;
          end
          icnt_n = g_val ? '0 : inext;
          if ((accept && (g_last ||
               wnext == WCW'(MAX_BURST))) ||
              (!g_val && inext == ICW'(IDLE_TO))) begin
            state_n = IDLE;
            grant_n = '0;
            ptr_n   = ptr_inc;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      state     <= IDLE;
      CH_GRANT  <= '0;
      gidx      <= '0;
      ptr       <= '0;
      wcnt      <= '0;
      icnt      <= '0;
      USER_TX_D <= '0;
      USER_TX_B <= '0;
      BAD_LEN   <= 1'b0;
    end else begin
      state     <= state_n;
      CH_GRANT  <= grant_n;
      gidx      <= gidx_n;
      ptr       <= ptr_n;
      wcnt      <= wcnt_n;
      icnt      <= icnt_n;
      USER_TX_D <= tx_d_n;
      USER_TX_B <= tx_b_n;
      BAD_LEN   <= bad_n;
    end
  end

endmodule
